// File: rtl/sid_multi_writer.sv
// SID multi-chip write sequencer.
// Queues register writes in a FIFO and plays them onto a shared SID bus,
// timed to the divided phi2 clock. Handles the SID reset sequence and
// reset requests without losing queued writes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET_SEQ  | sid_rst held low for RST_CYCLES phi2 rises, exit on a fall
// IDLE       | bus quiet, on each fall: pending reset, else pop, else wait
// WRITE      | one full phi2 period (fall to fall) with cs/rw/oe asserted
// GAP        | one quiet phi2 period; its closing fall makes the IDLE
//            | decision directly so back-to-back writes take 2 periods
module sid_multi_writer #(
  parameter int SYS_CLK    = 20000000,
  parameter int CLK_OUT    = 1000000,
  parameter int N_SID      = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int RST_CYCLES = 10,
  localparam int CW = (N_SID > 1) ? $clog2(N_SID) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CW-1:0]     wr_chip,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              sid_reset_req,
  output logic              sid_clk,
  output logic [4:0]        sid_addr,
  output logic [7:0]        sid_data,
  output logic              sid_data_oe,
  output logic [N_SID-1:0]  sid_cs_n,
  output logic              sid_rw,
  output logic              sid_rst,
  output logic [LW-1:0]     fifo_level,
  output logic              bad_chip
);

  localparam int HALF = (SYS_CLK / CLK_OUT) / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RCW  = $clog2(RST_CYCLES + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int EW   = CW + 13;

  typedef enum logic [1:0] {
    S_RESET_SEQ = 2'd0,
    S_IDLE      = 2'd1,
    S_WRITE     = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]  div_cnt;
  logic           div_tc, rise_evt, fall_evt;
  logic [RCW-1:0] rst_cnt;
  logic           rst_pend;
  logic           pop, end_write, enter_rs;
  logic           push;

  logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [EW-1:0]  head;
  logic [CW-1:0]  head_chip;
  logic [4:0]     head_addr;
  logic [7:0]     head_data;
  logic           head_bad;
  logic [N_SID-1:0] cs_dec;

  assign div_tc   = (div_cnt == DW'(HALF - 1));
  assign rise_evt = div_tc & ~sid_clk;
  assign fall_evt = div_tc & sid_clk;

  // phi2 divider: toggle every HALF system clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sid_clk <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      sid_clk <= ~sid_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign wr_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign head     = fifo_mem[rd_ptr];
  assign {head_chip, head_addr, head_data} = head;
  assign head_bad = ({1'b0, head_chip} >= (CW + 1)'(N_SID));

  // FIFO storage; contents need no reset since level/pointers gate them
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wr_chip, wr_addr, wr_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // chip-select decode of the FIFO head; out-of-range chips select nothing
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < N_SID; i++) begin
      if (head_chip == CW'(i)) cs_dec[i] = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET_SEQ;
    else     state <= state_nxt;
  end

  // next-state and sequencing strobes, all bus moves on phi2 falls
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    end_write = 1'b0;
    enter_rs  = 1'b0;
    case (state)
      S_RESET_SEQ: begin
        if (fall_evt && rst_cnt == '0) state_nxt = S_IDLE;
      end
      S_IDLE, S_GAP: begin
        if (fall_evt) begin
          if (rst_pend) begin
            state_nxt = S_RESET_SEQ;
            enter_rs  = 1'b1;
          end else if (fifo_level != '0) begin
            state_nxt = S_WRITE;
            pop       = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (fall_evt) begin
          state_nxt = S_GAP;
          end_write = 1'b1;
        end
      end
      default: state_nxt = S_RESET_SEQ;
    endcase
  end

  // reset-sequence length: down-count phi2 rises to zero
  always_ff @(posedge clk) begin
    if (rst || enter_rs) begin
      rst_cnt <= RCW'(RST_CYCLES);
    end else if (state == S_RESET_SEQ && rise_evt && rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 1'b1;
    end
  end

  // latch reset requests until the sequencer reaches IDLE
  always_ff @(posedge clk) begin
    if (rst)                rst_pend <= 1'b0;
    else if (sid_reset_req) rst_pend <= 1'b1;
    else if (enter_rs)      rst_pend <= 1'b0;
  end

  // bus output registers; addr/data keep their last value when not driven
  always_ff @(posedge clk) begin
    if (rst) begin
      sid_addr    <= '0;
      sid_data    <= '0;
      sid_data_oe <= 1'b0;
      sid_rw      <= 1'b1;
      sid_cs_n    <= '1;
      sid_rst     <= 1'b0;
      bad_chip    <= 1'b0;
    end else begin
      sid_rst <= (state_nxt != S_RESET_SEQ);
      if (pop) begin
        sid_addr    <= head_addr;
        sid_data    <= head_data;
        sid_data_oe <= 1'b1;
        sid_rw      <= 1'b0;
        sid_cs_n    <= cs_dec;
        if (head_bad) bad_chip <= 1'b1;
      end else if (end_write) begin
        sid_data_oe <= 1'b0;
        sid_rw      <= 1'b1;
        sid_cs_n    <= '1;
      end
    end
  end

endmodule

// File: tb/tb_sid_multi_writer.sv
// Directed bench for sid_multi_writer. Three chips are instantiated so that
// a 2-bit wr_chip can carry the out-of-range index 3.
module tb_sid_multi_writer;

  localparam int N_SID = 3;
  localparam int CW    = 2;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [CW-1:0]    wr_chip = '0;
  logic [4:0]       wr_addr = '0;
  logic [7:0]       wr_data = '0;
  logic             sid_reset_req = 1'b0;
  logic             sid_clk;
  logic [4:0]       sid_addr;
  logic [7:0]       sid_data;
  logic             sid_data_oe;
  logic [N_SID-1:0] sid_cs_n;
  logic             sid_rw;
  logic             sid_rst;
  logic [LW-1:0]    fifo_level;
  logic             bad_chip;

  sid_multi_writer #(
    .SYS_CLK(20000000), .CLK_OUT(1000000), .N_SID(N_SID),
    .FIFO_DEPTH(16), .RST_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chip(wr_chip), .wr_addr(wr_addr), .wr_data(wr_data),
    .sid_reset_req(sid_reset_req), .sid_clk(sid_clk), .sid_addr(sid_addr),
    .sid_data(sid_data), .sid_data_oe(sid_data_oe), .sid_cs_n(sid_cs_n),
    .sid_rw(sid_rw), .sid_rst(sid_rst), .fifo_level(fifo_level),
    .bad_chip(bad_chip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // expected bus word {cs_n, addr, data} for a command
  function automatic logic [15:0] ent(input int chip, input logic [4:0] a, input logic [7:0] d);
    logic [2:0] cs;
    cs = 3'b111;
    if (chip < N_SID) cs[chip] = 1'b0;
    return {cs, a, d};
  endfunction

  // bus monitor: logs every write start and sid_rst edges with a cycle stamp
  typedef struct { logic [15:0] v; int cyc; } wr_t;
  wr_t log_q[$];
  int  cyc = 0;
  int  rst_fall_cyc = -1;
  int  rst_rise_cyc = -1;
  logic oe_q = 1'b0;
  logic srst_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (sid_data_oe && !oe_q) log_q.push_back('{v: {sid_cs_n, sid_addr, sid_data}, cyc: cyc});
    if (!sid_rst && srst_q) rst_fall_cyc = cyc;
    if (sid_rst && !srst_q) rst_rise_cyc = cyc;
    oe_q   = sid_data_oe;
    srst_q = sid_rst;
  end

  int stall_level = -1;

  task automatic push(input int c, input logic [4:0] a, input logic [7:0] d);
    int g;
    g = 0;
    wr_chip  = CW'(c);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!wr_ready && g < 2000) begin
      if (stall_level < 0) stall_level = int'(fifo_level);
      @(negedge clk);
      g++;
    end
    if (g >= 2000) check("push_timeout", 0, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int g;
    g = 0;
    while (log_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (log_q.size() < n) check(tag, 0, 1);
  endtask

  task automatic wait_srst(input logic lvl, input int budget, input string tag);
    int g;
    g = 0;
    while (sid_rst !== lvl && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (sid_rst !== lvl) check(tag, 0, 1);
  endtask

  initial begin
    int n, n0, hi, lo, g;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs", sid_cs_n, 3'b111);
    check("rst_rw", sid_rw, 1);
    check("rst_oe", sid_data_oe, 0);
    check("rst_sid_rst", sid_rst, 0);
    check("rst_level", fifo_level, 0);
    check("rst_addr_data", {sid_addr, sid_data}, 13'h0);
    check("rst_bad", bad_chip, 0);
    check("rst_sidclk", sid_clk, 0);
    rst = 1'b0;
    check("rst_ready", wr_ready, 1);

    // reset sequence: 10 phi2 rises, release on the fall 200 clk later
    n = 0;
    while (!sid_rst && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rstseq_len", n, 200);
    check("rstseq_at_fall", sid_clk, 0);

    // phi2 shape: 10 high, 10 low
    g = 0;
    while (!sid_clk && g < 100) begin @(negedge clk); g++; end
    hi = 0;
    while (sid_clk && hi < 100) begin @(negedge clk); hi++; end
    lo = 0;
    while (!sid_clk && lo < 100) begin @(negedge clk); lo++; end
    check("sidclk_high", hi, 10);
    check("sidclk_low", lo, 10);

    // single write to chip 1
    push(1, 5'h18, 8'h0F);
    g = 0;
    while (!sid_data_oe && g < 200) begin @(negedge clk); g++; end
    check("wr1_cs", sid_cs_n, 3'b101);
    check("wr1_rw", sid_rw, 0);
    check("wr1_addr", sid_addr, 5'h18);
    check("wr1_data", sid_data, 8'h0F);
    check("wr1_at_fall", sid_clk, 0);
    n = 0;
    while (sid_data_oe && sid_cs_n == 3'b101 && !sid_rw && sid_addr == 5'h18
           && sid_data == 8'h0F && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wr1_hold", n, 20);
    check("wr1_end_cs", sid_cs_n, 3'b111);
    check("wr1_end_rw", sid_rw, 1);
    check("wr1_hold_addr", sid_addr, 5'h18);

    // out-of-range chip then a normal write
    check("bad_before", bad_chip, 0);
    n0 = log_q.size();
    push(3, 5'h01, 8'h22);
    push(2, 5'h02, 8'h33);
    wait_log(n0 + 2, 500, "bad_timeout");
    check("bad_entry", log_q[n0].v, ent(3, 5'h01, 8'h22));
    check("bad_next", log_q[n0 + 1].v, ent(2, 5'h02, 8'h33));
    check("bad_flag", bad_chip, 1);

    // 20 back-to-back pushes with backpressure
    repeat (60) @(negedge clk);
    n0 = log_q.size();
    stall_level = -1;
    for (int i = 0; i < 20; i++) push(i % 3, 5'(i), 8'(i * 7 + 3));
    check("burst_stall_level", stall_level, 16);
    wait_log(n0 + 20, 2000, "burst_timeout");
    for (int i = 0; i < 20; i++)
      check($sformatf("burst_%0d", i), log_q[n0 + i].v, ent(i % 3, 5'(i), 8'(i * 7 + 3)));
    check("burst_span", log_q[n0 + 19].cyc - log_q[n0].cyc, 760);
    check("burst_bad_sticky", bad_chip, 1);

    // reset request during a write with 3 more queued
    repeat (60) @(negedge clk);
    n0 = log_q.size();
    push(0, 5'h0A, 8'hA0);
    push(1, 5'h0B, 8'hB1);
    push(2, 5'h0C, 8'hC2);
    push(0, 5'h0D, 8'hD3);
    wait_log(n0 + 1, 200, "rreq_first_timeout");
    sid_reset_req = 1'b1;
    @(negedge clk);
    sid_reset_req = 1'b0;
    wait_srst(1'b0, 200, "rreq_enter_timeout");
    check("rreq_level_kept", fifo_level, 3);
    wait_log(n0 + 4, 1000, "rreq_drain_timeout");
    check("rreq_a", log_q[n0].v, ent(0, 5'h0A, 8'hA0));
    check("rreq_b", log_q[n0 + 1].v, ent(1, 5'h0B, 8'hB1));
    check("rreq_c", log_q[n0 + 2].v, ent(2, 5'h0C, 8'hC2));
    check("rreq_d", log_q[n0 + 3].v, ent(0, 5'h0D, 8'hD3));
    check("rreq_write_gap", rst_fall_cyc - log_q[n0].cyc, 40);
    check("rreq_rst_len", rst_rise_cyc - rst_fall_cyc, 200);
    check("rreq_resume", log_q[n0 + 1].cyc - rst_rise_cyc, 20);

    // rst mid-write aborts and flushes
    repeat (60) @(negedge clk);
    n0 = log_q.size();
    push(1, 5'h11, 8'h44);
    push(2, 5'h12, 8'h55);
    push(0, 5'h13, 8'h66);
    wait_log(n0 + 1, 200, "abort_first_timeout");
    repeat (5) @(negedge clk);
    check("abort_mid_write", sid_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", sid_cs_n, 3'b111);
    check("abort_level", fifo_level, 0);
    check("abort_oe", sid_data_oe, 0);
    check("abort_bad_clr", bad_chip, 0);
    check("abort_sid_rst", sid_rst, 0);
    rst = 1'b0;
    wait_srst(1'b1, 400, "abort_rstseq_timeout");
    repeat (100) @(negedge clk);
    check("abort_no_writes", log_q.size(), n0 + 1);
    check("abort_level_after", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
